// File: rtl/posit_divsqrt_arbiter.sv
// -----------------------------------------------------------------------------
// posit_divsqrt_arbiter
//
// Shares a single posit divide/square-root unit among NUM_REQ requesters.
// A round-robin arbiter picks one request while the unit is idle, captures its
// operands, issues a one-cycle start pulse and holds the unit's result in a
// response register until the consumer takes it. Flush aborts whatever is
// pending: the unit is killed if it was started (or about to be), and any
// held response is dropped.
//
// Ports
//   Clk_CI, Rst_RBI        clock, asynchronous active-low reset
//   Flush_SI               abort in-flight/pending op, drop held response
//   Req_*                  per-requester valid/op/operands/rm/fmt/tag (packed)
//   Req_ready_SO           one-hot accept, only asserted while idle
//   Rsp_*                  held response with valid/ready handshake
//   Div_start_SO,
//   Sqrt_start_SO          one-cycle start pulses to the unit
//   Operand_a_DO/b_DO,
//   RM_SO, Format_sel_SO   registered operation fields to the unit
//   Kill_SO                abort pulse to the unit
//   Result_DI, Fflags_DI,
//   Ready_DI, Done_DI      status/result from the unit
// -----------------------------------------------------------------------------
module posit_divsqrt_arbiter #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RBI,
  input  logic                         Flush_SI,
  input  logic [NUM_REQ-1:0]           Req_valid_SI,
  input  logic [NUM_REQ-1:0]           Req_sqrt_SI,
  input  logic [NUM_REQ*N-1:0]         Req_a_DI,
  input  logic [NUM_REQ*N-1:0]         Req_b_DI,
  input  logic [NUM_REQ*3-1:0]         Req_rm_SI,
  input  logic [NUM_REQ*2-1:0]         Req_fmt_SI,
  input  logic [NUM_REQ*TAG_W-1:0]     Req_tag_DI,
  output logic [NUM_REQ-1:0]           Req_ready_SO,
  output logic                         Rsp_valid_SO,
  input  logic                         Rsp_ready_SI,
  output logic [$clog2(NUM_REQ)-1:0]   Rsp_id_DO,
  output logic [TAG_W-1:0]             Rsp_tag_DO,
  output logic [N-1:0]                 Rsp_result_DO,
  output logic [4:0]                   Rsp_fflags_DO,
  output logic                         Div_start_SO,
  output logic                         Sqrt_start_SO,
  output logic [N-1:0]                 Operand_a_DO,
  output logic [N-1:0]                 Operand_b_DO,
  output logic [2:0]                   RM_SO,
  output logic [1:0]                   Format_sel_SO,
  output logic                         Kill_SO,
  input  logic [N-1:0]                 Result_DI,
  input  logic [4:0]                   Fflags_DI,
  input  logic                         Ready_DI,
  input  logic                         Done_DI
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic [ID_W:0]     cand;
  logic              accept;

  logic              op_sqrt_q;
  logic [N-1:0]      a_q, b_q;
  logic [2:0]        rm_q;
  logic [1:0]        fmt_q;
  logic [TAG_W-1:0]  tag_q;
  logic [ID_W-1:0]   id_q;
  logic [N-1:0]      result_q;
  logic [4:0]        fflags_q;

  // Round-robin pick: scan from the pointer upwards, wrapping past NUM_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_found && Req_valid_SI[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign accept       = (state_q == IDLE) && grant_found && Ready_DI && !Flush_SI;
  assign Req_ready_SO = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  // Next state and unit-facing control. Flush overrides every transition,
  // including a coincident Done_DI or response handshake.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    Div_start_SO  = 1'b0;
    Sqrt_start_SO = 1'b0;
    Kill_SO       = 1'b0;
    Rsp_valid_SO  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (Flush_SI) begin
          Kill_SO = 1'b1;
          state_d = IDLE;
        end else begin
          Div_start_SO  = !op_sqrt_q;
          Sqrt_start_SO = op_sqrt_q;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (Flush_SI) begin
          Kill_SO = 1'b1;
          state_d = IDLE;
        end else if (Done_DI) begin
          state_d = RESP;
        end
      end
      RESP: begin
        Rsp_valid_SO = 1'b1;
        if (Flush_SI) begin
          state_d = IDLE;
        end else if (Rsp_ready_SI) begin
          state_d = IDLE;
          if (id_q == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
          else                            rr_ptr_d = id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Operation capture on accept; result capture on Done while busy.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      op_sqrt_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rm_q      <= '0;
      fmt_q     <= '0;
      tag_q     <= '0;
      id_q      <= '0;
      result_q  <= '0;
      fflags_q  <= '0;
    end else begin
      if (accept) begin
        op_sqrt_q <= Req_sqrt_SI[grant_idx];
        a_q       <= Req_a_DI[int'(grant_idx)*N +: N];
        // b is forced to zero for sqrt so the unit sees a clean operand.
        b_q       <= Req_sqrt_SI[grant_idx] ? '0 : Req_b_DI[int'(grant_idx)*N +: N];
        rm_q      <= Req_rm_SI[int'(grant_idx)*3 +: 3];
        fmt_q     <= Req_fmt_SI[int'(grant_idx)*2 +: 2];
        tag_q     <= Req_tag_DI[int'(grant_idx)*TAG_W +: TAG_W];
        id_q      <= grant_idx;
      end
      if ((state_q == BUSY) && Done_DI && !Flush_SI) begin
        result_q <= Result_DI;
        fflags_q <= Fflags_DI;
      end
    end
  end

  assign Operand_a_DO  = a_q;
  assign Operand_b_DO  = b_q;
  assign RM_SO         = rm_q;
  assign Format_sel_SO = fmt_q;
  assign Rsp_id_DO     = id_q;
  assign Rsp_tag_DO    = tag_q;
  assign Rsp_result_DO = result_q;
  assign Rsp_fflags_DO = fflags_q;

endmodule

// File: tb/tb_posit_divsqrt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_posit_divsqrt_arbiter
//
// Directed bench for posit_divsqrt_arbiter. The bench plays both the
// requesters and the divsqrt unit. Single-requester transactions come from a
// vector table; fairness, backpressure, flush and reset are hand sequences.
// -----------------------------------------------------------------------------
module tb_posit_divsqrt_arbiter;

  localparam int N = 32;
  localparam int NR = 4;
  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NR-1:0]     req_valid, req_sqrt, req_ready;
  logic [NR*N-1:0]   req_a, req_b;
  logic [NR*3-1:0]   req_rm;
  logic [NR*2-1:0]   req_fmt;
  logic [NR*TW-1:0]  req_tag;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [TW-1:0]     rsp_tag;
  logic [N-1:0]      rsp_result;
  logic [4:0]        rsp_fflags;
  logic              div_start, sqrt_start, kill;
  logic [N-1:0]      op_a, op_b;
  logic [2:0]        rm;
  logic [1:0]        fmt;
  logic [N-1:0]      unit_result;
  logic [4:0]        unit_fflags;
  logic              unit_ready, unit_done;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  posit_divsqrt_arbiter #(.N(N), .NUM_REQ(NR), .TAG_W(TW)) dut (
    .Clk_CI        (clk),
    .Rst_RBI       (rst_n),
    .Flush_SI      (flush),
    .Req_valid_SI  (req_valid),
    .Req_sqrt_SI   (req_sqrt),
    .Req_a_DI      (req_a),
    .Req_b_DI      (req_b),
    .Req_rm_SI     (req_rm),
    .Req_fmt_SI    (req_fmt),
    .Req_tag_DI    (req_tag),
    .Req_ready_SO  (req_ready),
    .Rsp_valid_SO  (rsp_valid),
    .Rsp_ready_SI  (rsp_ready),
    .Rsp_id_DO     (rsp_id),
    .Rsp_tag_DO    (rsp_tag),
    .Rsp_result_DO (rsp_result),
    .Rsp_fflags_DO (rsp_fflags),
    .Div_start_SO  (div_start),
    .Sqrt_start_SO (sqrt_start),
    .Operand_a_DO  (op_a),
    .Operand_b_DO  (op_b),
    .RM_SO         (rm),
    .Format_sel_SO (fmt),
    .Kill_SO       (kill),
    .Result_DI     (unit_result),
    .Fflags_DI     (unit_fflags),
    .Ready_DI      (unit_ready),
    .Done_DI       (unit_done)
  );

  typedef struct {
    int          req;
    logic        sqrt;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [1:0]  fmt;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic sq, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] r, input logic [1:0] f, input logic [3:0] t);
    req_valid[i]          = 1'b1;
    req_sqrt[i]           = sq;
    req_a[i*N +: N]       = a;
    req_b[i*N +: N]       = b;
    req_rm[i*3 +: 3]      = r;
    req_fmt[i*2 +: 2]     = f;
    req_tag[i*TW +: TW]   = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.req;
    req_valid = '0;
    set_req(v.req, v.sqrt, v.a, v.b, v.rm, v.fmt, v.tag);
    unit_ready = 1'b1;
    rsp_ready  = 1'b1;
    #1;
    chk("vec_grant", 64'(req_ready), 64'(oh));
    tick();                                   // ISSUE
    req_valid = '0;
    #1;
    chk("vec_div_start",  64'(div_start),  64'(!v.sqrt));
    chk("vec_sqrt_start", 64'(sqrt_start), 64'(v.sqrt));
    chk("vec_op_a", 64'(op_a), 64'(v.a));
    chk("vec_op_b", 64'(op_b), 64'(v.sqrt ? 32'h0 : v.b));
    chk("vec_rm",   64'(rm),   64'(v.rm));
    chk("vec_fmt",  64'(fmt),  64'(v.fmt));
    tick();                                   // BUSY
    chk("vec_start_once", 64'({div_start, sqrt_start}), 64'(0));
    chk("vec_no_rsp_busy", 64'(rsp_valid), 64'(0));
    tick();
    tick();
    unit_done   = 1'b1;
    unit_result = v.res;
    unit_fflags = v.flags;
    #1;
    chk("vec_no_rsp_done", 64'(rsp_valid), 64'(0));
    tick();                                   // RESP
    unit_done   = 1'b0;
    unit_result = '1;
    unit_fflags = '1;
    #1;
    chk("vec_rsp_valid",  64'(rsp_valid),  64'(1));
    chk("vec_rsp_id",     64'(rsp_id),     64'(v.req));
    chk("vec_rsp_tag",    64'(rsp_tag),    64'(v.tag));
    chk("vec_rsp_result", 64'(rsp_result), 64'(v.res));
    chk("vec_rsp_fflags", 64'(rsp_fflags), 64'(v.flags));
    tick();                                   // back to IDLE
    chk("vec_rsp_drop", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    vecs[0] = '{req: 0, sqrt: 1'b0, a: 32'h6B31C72A, b: 32'h48000000, rm: 3'd0, fmt: 2'd0,
                tag: 4'h5, res: 32'h5A827999, flags: 5'b00000};
    vecs[1] = '{req: 2, sqrt: 1'b1, a: 32'h6B31C72A, b: 32'h12345678, rm: 3'd3, fmt: 2'd2,
                tag: 4'hA, res: 32'h62000000, flags: 5'b00001};
    vecs[2] = '{req: 3, sqrt: 1'b0, a: 32'h40000000, b: 32'h00000000, rm: 3'd1, fmt: 2'd1,
                tag: 4'hF, res: 32'h80000000, flags: 5'b01000};
    vecs[3] = '{req: 1, sqrt: 1'b1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, rm: 3'd4, fmt: 2'd3,
                tag: 4'h0, res: 32'h80000000, flags: 5'b10000};

    rst_n       = 1'b0;
    flush       = 1'b0;
    req_valid   = '0;
    req_sqrt    = '0;
    req_a       = '0;
    req_b       = '0;
    req_rm      = '0;
    req_fmt     = '0;
    req_tag     = '0;
    rsp_ready   = 1'b0;
    unit_result = '0;
    unit_fflags = '0;
    unit_ready  = 1'b1;
    unit_done   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_ready",     64'(req_ready), 64'(0));
    chk("rst_starts",    64'({div_start, sqrt_start, kill}), 64'(0));
    chk("rst_op_a",      64'(op_a), 64'(0));
    chk("rst_result",    64'(rsp_result), 64'(0));
    rst_n = 1'b1;

    // Done while idle is ignored
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    #1;
    chk("idle_done_ignored", 64'(rsp_valid), 64'(0));

    // Unit not ready blocks the grant
    unit_ready = 1'b0;
    set_req(0, 1'b0, 32'h11111111, 32'h22222222, 3'd0, 2'd0, 4'h1);
    #1;
    chk("notready_grant", 64'(req_ready), 64'(0));
    tick();
    chk("notready_no_start", 64'(div_start), 64'(0));
    chk("notready_no_latch", 64'(op_a), 64'(0));
    req_valid  = '0;
    unit_ready = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Fairness from a fresh pointer, then backpressure on the fifth grant
    do_reset();
    for (int i = 0; i < NR; i++)
      set_req(i, i[0], 32'h10000000 * (i + 1), 32'h01000000 * (i + 1), 3'(i), 2'(i), 4'(i + 8));
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int e;
      e = g % NR;
      #1;
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << e));
      tick();                                 // ISSUE
      chk("rr_op_a", 64'(op_a), 64'(32'h10000000 * (e + 1)));
      chk("rr_div_start", 64'(div_start), 64'(e % 2 == 0));
      tick();                                 // BUSY
      unit_done   = 1'b1;
      unit_result = 32'hC0DE0000 | 32'(e);
      chk("rr_no_ready_busy", 64'(req_ready), 64'(0));
      if (g == 4) rsp_ready = 1'b0;
      tick();                                 // RESP
      unit_done   = 1'b0;
      unit_result = '0;
      if (g < 4) begin
        chk("rr_rsp_id", 64'(rsp_id), 64'(e));
        tick();
      end
    end

    // Backpressure: response held for 10 cycles, nothing else happens
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid",  64'(rsp_valid),  64'(1));
      chk("bp_result", 64'(rsp_result), 64'(32'hC0DE0000));
      chk("bp_id",     64'(rsp_id),     64'(0));
      chk("bp_quiet",  64'({req_ready, div_start, sqrt_start}), 64'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();                                   // handshake done, pointer now 1
    chk("bp_next_grant", 64'(req_ready), 64'(4'b0010));

    // Flush in BUSY: kill pulse, no response, pointer unchanged
    tick();                                   // ISSUE
    tick();                                   // BUSY
    flush = 1'b1;
    #1;
    chk("fl_busy_kill",  64'(kill), 64'(1));
    chk("fl_busy_ready", 64'(req_ready), 64'(0));
    tick();
    flush = 1'b0;
    #1;
    chk("fl_kill_once",   64'(kill), 64'(0));
    chk("fl_no_rsp",      64'(rsp_valid), 64'(0));
    chk("fl_regrant",     64'(req_ready), 64'(4'b0010));

    // Flush coinciding with Done: result discarded
    tick();                                   // ISSUE
    tick();                                   // BUSY
    flush       = 1'b1;
    unit_done   = 1'b1;
    unit_result = 32'hDEADBEEF;
    #1;
    chk("fl_done_kill", 64'(kill), 64'(1));
    tick();
    flush     = 1'b0;
    unit_done = 1'b0;
    req_valid = '0;
    #1;
    chk("fl_done_no_rsp", 64'(rsp_valid), 64'(0));
    tick();
    chk("fl_done_no_rsp2", 64'(rsp_valid), 64'(0));

    // Flush in ISSUE: start suppressed
    req_valid = 4'b1000;
    #1;
    chk("fl_issue_grant", 64'(req_ready), 64'(4'b1000));
    tick();                                   // ISSUE
    flush     = 1'b1;
    req_valid = '0;
    #1;
    chk("fl_issue_kill",  64'(kill), 64'(1));
    chk("fl_issue_nostart", 64'({div_start, sqrt_start}), 64'(0));
    tick();
    flush = 1'b0;
    #1;
    chk("fl_issue_after", 64'({div_start, sqrt_start, kill}), 64'(0));

    // Asynchronous reset while BUSY
    req_valid = 4'b0100;
    #1;
    chk("rb_grant", 64'(req_ready), 64'(4'b0100));
    tick();                                   // ISSUE
    req_valid = '0;
    tick();                                   // BUSY
    chk("rb_op_a_before", 64'(op_a), 64'(32'h30000000));
    rst_n = 1'b0;
    #1;
    chk("rb_op_a",   64'(op_a), 64'(0));
    chk("rb_ctrl",   64'({kill, div_start, sqrt_start, rsp_valid}), 64'(0));
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rb_ptr_zero", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
